dcache_ctrl: RTL and testbench

- Direct-mapped, write-back, write-allocate L1 data cache controller between the CPU MEM stage and the 256-bit line-based data memory.
- Serves 32-bit word loads and stores from internal tag, valid, dirty and data arrays.
- On a miss it stalls the CPU, writes back a dirty victim line, refills the line over the memory enable/write/ack handshake, then completes the access.
- Keeps hit and miss counters for performance measurement.

---
 rtl/dcache_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_dcache_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate L1 data cache controller.
// Serves 32-bit CPU words from 256-bit lines; misses write back / refill over a req/ack memory port.
module dcache_ctrl #(
    parameter int unsigned NUM_LINES = 32,
    parameter int unsigned CNT_W     = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             cpu_req_i,
    input  logic             cpu_we_i,
    input  logic [31:0]      cpu_addr_i,
    input  logic [31:0]      cpu_wdata_i,
    output logic [31:0]      cpu_rdata_o,
    output logic             cpu_stall_o,
    output logic [31:0]      mem_addr_o,
    output logic [255:0]     mem_data_o,
    output logic             mem_enable_o,
    output logic             mem_write_o,
    input  logic             mem_ack_i,
    input  logic [255:0]     mem_data_i,
    output logic [CNT_W-1:0] hit_cnt_o,
    output logic [CNT_W-1:0] miss_cnt_o
);

    localparam int unsigned INDEX_W = $clog2(NUM_LINES);
    localparam int unsigned TAG_W   = 27 - INDEX_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITEBACK,
        S_REFILL,
        S_ALLOCATE
    } state_e;

    state_e state_q, state_d;

    logic [255:0]     data_q [NUM_LINES];
    logic [TAG_W-1:0] tag_q  [NUM_LINES];
    logic [NUM_LINES-1:0] valid_q, valid_d;
    logic [NUM_LINES-1:0] dirty_q, dirty_d;

    logic             mem_enable_q, mem_enable_d;
    logic             mem_write_q,  mem_write_d;
    logic [31:0]      mem_addr_q,   mem_addr_d;
    logic [255:0]     mem_data_q,   mem_data_d;
    logic [CNT_W-1:0] hit_cnt_q,    hit_cnt_d;
    logic [CNT_W-1:0] miss_cnt_q,   miss_cnt_d;

    logic [2:0]         word_sel;
    logic [INDEX_W-1:0] index;
    logic [TAG_W-1:0]   tag;
    logic [255:0]       cur_line;
    logic [TAG_W-1:0]   cur_tag;
    logic               hit;

    logic               line_we;
    logic [255:0]       line_wdata;
    logic               tag_we;
    logic               unused_addr;

    assign word_sel    = cpu_addr_i[4:2];
    assign index       = cpu_addr_i[5 +: INDEX_W];
    assign tag         = cpu_addr_i[31 -: TAG_W];
    assign unused_addr = ^cpu_addr_i[1:0];

    assign cur_line = data_q[index];
    assign cur_tag  = tag_q[index];

    assign hit         = cpu_req_i & valid_q[index] & (cur_tag == tag) & (state_q == S_IDLE);
    assign cpu_stall_o = cpu_req_i & ~hit;
    assign cpu_rdata_o = hit ? cur_line[{word_sel, 5'b0} +: 32] : '0;

    assign mem_enable_o = mem_enable_q;
    assign mem_write_o  = mem_write_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_data_o   = mem_data_q;
    assign hit_cnt_o    = hit_cnt_q;
    assign miss_cnt_o   = miss_cnt_q;

    // Each memory phase opens with one enable-low cycle that loads addr/data/write;
    // this is also the mandatory gap between write-back and refill.
    always_comb begin
        state_d      = state_q;
        valid_d      = valid_q;
        dirty_d      = dirty_q;
        mem_enable_d = mem_enable_q;
        mem_write_d  = mem_write_q;
        mem_addr_d   = mem_addr_q;
        mem_data_d   = mem_data_q;
        hit_cnt_d    = hit_cnt_q;
        miss_cnt_d   = miss_cnt_q;
        line_we      = 1'b0;
        line_wdata   = cur_line;
        tag_we       = 1'b0;

        if (hit) begin
            hit_cnt_d = hit_cnt_q + CNT_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                mem_enable_d = 1'b0;
                if (hit && cpu_we_i) begin
                    line_we = 1'b1;
                    line_wdata[{word_sel, 5'b0} +: 32] = cpu_wdata_i;
                    dirty_d[index] = 1'b1;
                end else if (cpu_req_i && !hit) begin
                    miss_cnt_d = miss_cnt_q + CNT_W'(1);
                    if (valid_q[index] && dirty_q[index]) begin
                        state_d     = S_WRITEBACK;
                        mem_write_d = 1'b1;
                        mem_addr_d  = {cur_tag, index, 5'b0};
                        mem_data_d  = cur_line;
                    end else begin
                        state_d     = S_REFILL;
                        mem_write_d = 1'b0;
                        mem_addr_d  = {tag, index, 5'b0};
                    end
                end
            end
            S_WRITEBACK: begin
                if (mem_enable_q && mem_ack_i) begin
                    state_d      = S_REFILL;
                    mem_enable_d = 1'b0;
                    mem_write_d  = 1'b0;
                    mem_addr_d   = {tag, index, 5'b0};
                end else begin
                    mem_enable_d = 1'b1;
                end
            end
            S_REFILL: begin
                if (mem_enable_q && mem_ack_i) begin
                    state_d        = S_ALLOCATE;
                    mem_enable_d   = 1'b0;
                    line_we        = 1'b1;
                    line_wdata     = mem_data_i;
                    tag_we         = 1'b1;
                    valid_d[index] = 1'b1;
                    dirty_d[index] = 1'b0;
                end else begin
                    mem_enable_d = 1'b1;
                end
            end
            S_ALLOCATE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q      <= S_IDLE;
            valid_q      <= '0;
            dirty_q      <= '0;
            mem_enable_q <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
            hit_cnt_q    <= '0;
            miss_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            valid_q      <= valid_d;
            dirty_q      <= dirty_d;
            mem_enable_q <= mem_enable_d;
            mem_write_q  <= mem_write_d;
            mem_addr_q   <= mem_addr_d;
            mem_data_q   <= mem_data_d;
            hit_cnt_q    <= hit_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
        end
    end

    // Tag and data storage carry no reset; validity alone decides residency.
    always_ff @(posedge clk_i) begin
        if (line_we) begin
            data_q[index] <= line_wdata;
        end
        if (tag_we) begin
            tag_q[index] <= tag;
        end
    end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl: vector table of CPU accesses against a line memory
// model with fixed ack latency, plus hand-written reset-abort sequence.
module tb_dcache_ctrl;

    localparam int unsigned L = 8;

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b0;
    logic         cpu_req_i = 1'b0;
    logic         cpu_we_i = 1'b0;
    logic [31:0]  cpu_addr_i = '0;
    logic [31:0]  cpu_wdata_i = '0;
    logic [31:0]  cpu_rdata_o;
    logic         cpu_stall_o;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_data_o;
    logic         mem_enable_o;
    logic         mem_write_o;
    logic         mem_ack_i;
    logic [255:0] mem_data_i;
    logic [31:0]  hit_cnt_o;
    logic [31:0]  miss_cnt_o;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    dcache_ctrl #(.NUM_LINES(32), .CNT_W(32)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .cpu_req_i   (cpu_req_i),
        .cpu_we_i    (cpu_we_i),
        .cpu_addr_i  (cpu_addr_i),
        .cpu_wdata_i (cpu_wdata_i),
        .cpu_rdata_o (cpu_rdata_o),
        .cpu_stall_o (cpu_stall_o),
        .mem_addr_o  (mem_addr_o),
        .mem_data_o  (mem_data_o),
        .mem_enable_o(mem_enable_o),
        .mem_write_o (mem_write_o),
        .mem_ack_i   (mem_ack_i),
        .mem_data_i  (mem_data_i),
        .hit_cnt_o   (hit_cnt_o),
        .miss_cnt_o  (miss_cnt_o)
    );

    // Line memory: word w of line at address A is {A[15:0], 16'(w)}, except line 0x40.
    logic [255:0] mem [2048];
    int unsigned  ack_cnt;
    int           wb_cnt = 0;
    int           rf_cnt = 0;
    logic [31:0]  last_wb_addr = '0;
    logic [31:0]  last_rf_addr = '0;

    assign mem_data_i = mem[mem_addr_o[15:5]];

    initial begin
        for (int i = 0; i < 2048; i++) begin
            logic [31:0]  la;
            logic [255:0] ln;
            la = i * 32;
            for (int w = 0; w < 8; w++) ln[w*32 +: 32] = {la[15:0], 16'(w)};
            if (i == 2) begin
                for (int w = 0; w < 8; w++) ln[w*32 +: 32] = 32'h1111_1111 * (w + 1);
            end
            mem[i] <= ln;
        end
    end

    // Ack is high during the L-th cycle that enable is high.
    always @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            mem_ack_i <= 1'b0;
            ack_cnt   <= 0;
        end else if (mem_enable_o && !mem_ack_i) begin
            if (ack_cnt == L - 2) mem_ack_i <= 1'b1;
            ack_cnt <= ack_cnt + 1;
        end else begin
            if (mem_enable_o && mem_ack_i) begin
                if (mem_write_o) begin
                    mem[mem_addr_o[15:5]] <= mem_data_o;
                    wb_cnt       <= wb_cnt + 1;
                    last_wb_addr <= mem_addr_o;
                end else begin
                    rf_cnt       <= rf_cnt + 1;
                    last_rf_addr <= mem_addr_o;
                end
            end
            mem_ack_i <= 1'b0;
            ack_cnt   <= 0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                          output int stalls, output logic [31:0] rd, output logic timeout);
        cpu_req_i   = 1'b1;
        cpu_we_i    = we;
        cpu_addr_i  = addr;
        cpu_wdata_i = wd;
        stalls      = 0;
        rd          = '0;
        timeout     = 1'b1;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk_i);
            if (!cpu_stall_o) begin
                rd      = cpu_rdata_o;
                timeout = 1'b0;
                break;
            end
            stalls++;
        end
        @(posedge clk_i);
        #1;
        cpu_req_i = 1'b0;
        cpu_we_i  = 1'b0;
    endtask

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        int          exp_stall;
        int          exp_wb;
        int          exp_rf;
    } vec_t;

    vec_t vecs[$];
    int   exp_hits = 0;
    int   exp_miss = 0;

    initial begin
        int          st;
        logic [31:0] rd;
        logic        to;
        int          rf_before;

        vecs.push_back('{1'b0, 32'h0000_0040, 32'h0, 32'h1111_1111, 11, 0, 1});
        vecs.push_back('{1'b0, 32'h0000_0044, 32'h0, 32'h2222_2222,  0, 0, 1});
        vecs.push_back('{1'b1, 32'h0000_0048, 32'hDEAD_BEEF, 32'h0,  0, 0, 1});
        vecs.push_back('{1'b0, 32'h0000_0448, 32'h0, 32'h0440_0002, 20, 1, 2});
        vecs.push_back('{1'b0, 32'h0000_0040, 32'h0, 32'h1111_1111, 11, 1, 3});
        vecs.push_back('{1'b0, 32'h0000_0048, 32'h0, 32'hDEAD_BEEF,  0, 1, 3});
        vecs.push_back('{1'b0, 32'h0000_1000, 32'h0, 32'h1000_0000, 11, 1, 4});
        vecs.push_back('{1'b0, 32'h0000_2020, 32'h0, 32'h2020_0000, 11, 1, 5});
        vecs.push_back('{1'b0, 32'h0000_3060, 32'h0, 32'h3060_0000, 11, 1, 6});
        vecs.push_back('{1'b0, 32'h0000_1004, 32'h0, 32'h1000_0001,  0, 1, 6});
        vecs.push_back('{1'b0, 32'h0000_2028, 32'h0, 32'h2020_0002,  0, 1, 6});
        vecs.push_back('{1'b0, 32'h0000_306C, 32'h0, 32'h3060_0003,  0, 1, 6});
        vecs.push_back('{1'b0, 32'h0000_005C, 32'h0, 32'h8888_8888,  0, 1, 6});
        vecs.push_back('{1'b1, 32'h0000_0484, 32'hCAFE_F00D, 32'h0, 11, 1, 7});
        vecs.push_back('{1'b0, 32'h0000_0484, 32'h0, 32'hCAFE_F00D,  0, 1, 7});
        vecs.push_back('{1'b0, 32'h0000_0084, 32'h0, 32'h0080_0001, 20, 2, 8});
        vecs.push_back('{1'b0, 32'h0000_0484, 32'h0, 32'hCAFE_F00D, 11, 2, 9});

        // Reset state
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_hit_cnt", hit_cnt_o, 32'd0);
        check("rst_miss_cnt", miss_cnt_o, 32'd0);
        check("rst_mem_enable", {31'd0, mem_enable_o}, 32'd0);
        check("rst_mem_write", {31'd0, mem_write_o}, 32'd0);
        check("rst_mem_addr", mem_addr_o, 32'd0);
        check("rst_mem_data_w0", mem_data_o[31:0], 32'd0);
        check("idle_stall", {31'd0, cpu_stall_o}, 32'd0);
        check("idle_rdata", cpu_rdata_o, 32'd0);
        @(negedge clk_i);
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;

        for (int i = 0; i < vecs.size(); i++) begin
            access(vecs[i].we, vecs[i].addr, vecs[i].wdata, st, rd, to);
            exp_hits++;
            if (vecs[i].exp_stall != 0) exp_miss++;
            check($sformatf("v%0d_timeout", i), {31'd0, to}, 32'd0);
            check($sformatf("v%0d_stall", i), st, vecs[i].exp_stall);
            if (!vecs[i].we) check($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rdata);
            check($sformatf("v%0d_hit_cnt", i), hit_cnt_o, exp_hits);
            check($sformatf("v%0d_miss_cnt", i), miss_cnt_o, exp_miss);
            check($sformatf("v%0d_wb_cnt", i), wb_cnt, vecs[i].exp_wb);
            check($sformatf("v%0d_rf_cnt", i), rf_cnt, vecs[i].exp_rf);
            if (vecs[i].exp_wb != 0 && vecs[i].exp_stall == 20 && vecs[i].addr == 32'h448) begin
                check("wb_addr", last_wb_addr, 32'h0000_0040);
                check("rf_addr", last_rf_addr, 32'h0000_0440);
                check("wb_word2", mem[2][95:64], 32'hDEAD_BEEF);
            end
        end
        check("store_miss_wb_word1", mem[36][63:32], 32'hCAFE_F00D);

        // Reset during a refill, before ack
        rf_before  = rf_cnt;
        cpu_req_i  = 1'b1;
        cpu_we_i   = 1'b0;
        cpu_addr_i = 32'h0000_0500;
        to = 1'b1;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk_i);
            if (mem_enable_o) begin
                to = 1'b0;
                break;
            end
        end
        check("abort_enable_seen_timeout", {31'd0, to}, 32'd0);
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        check("abort_mem_enable", {31'd0, mem_enable_o}, 32'd0);
        check("abort_hit_cnt", hit_cnt_o, 32'd0);
        check("abort_miss_cnt", miss_cnt_o, 32'd0);
        cpu_req_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        exp_hits = 0;
        exp_miss = 0;

        access(1'b0, 32'h0000_0500, 32'h0, st, rd, to);
        check("post_rst_timeout", {31'd0, to}, 32'd0);
        check("post_rst_stall", st, 11);
        check("post_rst_rdata", rd, 32'h0500_0000);
        check("post_rst_hit_cnt", hit_cnt_o, 32'd1);
        check("post_rst_miss_cnt", miss_cnt_o, 32'd1);
        check("post_rst_rf_cnt", rf_cnt, rf_before + 1);
        access(1'b0, 32'h0000_0040, 32'h0, st, rd, to);
        check("post_rst_old_line_stall", st, 11);
        check("post_rst_old_line_rdata", rd, 32'h1111_1111);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
